// File: rtl/spi_frame_arbiter.sv
// spi_frame_arbiter
//   Two requesters share one SPI byte engine. Whole frames are granted
//   round-robin. The grantee's active-low chip select is driven with setup,
//   hold and gap timing, and bytes are streamed between the grantee and the
//   engine.
// Ports
//   clk, rst          system clock; synchronous active-high reset
//   req[1:0]          per-requester frame request (level)
//   gnt[1:0]          one-hot frame grant, held through CS hold
//   tx_data[15:0]     byte from requester i on [8i+7:8i]
//   tx_valid/last     byte valid / last byte of frame
//   tx_ready[1:0]     byte accepted (grantee only, WAIT only, engine idle)
//   rx_data[7:0]      byte received from the engine, shared
//   rx_valid[1:0]     1-cycle pulse to the grantee with rx_data
//   err_timeout[1:0]  1-cycle pulse to the grantee when a stalled frame aborts
//   cs_n[1:0]         active-low chip selects
//   eng_start/eng_tx  1-cycle start pulse and byte for the engine
//   eng_busy/done/rx  engine status, completion pulse and received byte
module spi_frame_arbiter #(
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned CS_GAP   = 4,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  output logic [1:0]  gnt,
  input  logic [15:0] tx_data,
  input  logic [1:0]  tx_valid,
  input  logic [1:0]  tx_last,
  output logic [1:0]  tx_ready,
  output logic [7:0]  rx_data,
  output logic [1:0]  rx_valid,
  output logic [1:0]  err_timeout,
  output logic [1:0]  cs_n,
  output logic        eng_start,
  output logic [7:0]  eng_tx,
  input  logic        eng_busy,
  input  logic        eng_done,
  input  logic [7:0]  eng_rx
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_WAIT, ST_BUSY, ST_HOLD, ST_GAP
  } state_t;

  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
  localparam logic [7:0] GAP_LAST   = 8'(CS_GAP - 1);
  localparam logic [7:0] STALL_LAST = 8'(TIMEOUT - 1);

  state_t     r_state;
  logic       r_ptr;
  logic       r_owner;
  logic       r_last;
  logic [7:0] r_cnt;    // shared by SETUP, HOLD and GAP
  logic [7:0] r_stall;
  logic [1:0] r_gnt;
  logic [1:0] r_cs_n;
  logic [1:0] r_rx_valid;
  logic [1:0] r_err;
  logic       r_eng_start;
  logic [7:0] r_eng_tx;
  logic [7:0] r_rx_data;

  logic       w_win;
  logic [1:0] w_win_oh;
  logic [1:0] w_owner_oh;
  logic       w_tx_valid;
  logic       w_tx_last;
  logic [7:0] w_tx_byte;
  logic [1:0] w_tx_ready;

  always_comb begin
    // The pointer's requester wins if it is asking; otherwise the other one.
    w_win      = req[r_ptr] ? r_ptr : ~r_ptr;
    w_win_oh   = w_win ? 2'b10 : 2'b01;
    w_owner_oh = r_owner ? 2'b10 : 2'b01;
    w_tx_valid = tx_valid[r_owner];
    w_tx_last  = tx_last[r_owner];
    w_tx_byte  = r_owner ? tx_data[15:8] : tx_data[7:0];
    w_tx_ready = (r_state == ST_WAIT && !eng_busy) ? w_owner_oh : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= 1'b0;
      r_owner     <= 1'b0;
      r_last      <= 1'b0;
      r_cnt       <= '0;
      r_stall     <= '0;
      r_gnt       <= '0;
      r_cs_n      <= '1;
      r_rx_valid  <= '0;
      r_err       <= '0;
      r_eng_start <= 1'b0;
      r_eng_tx    <= '0;
      r_rx_data   <= '0;
    end else begin
      r_eng_start <= 1'b0;
      r_rx_valid  <= '0;
      r_err       <= '0;
      unique case (r_state)
        ST_IDLE: begin
          if (req != '0) begin
            r_owner <= w_win;
            r_ptr   <= ~w_win;
            r_gnt   <= w_win_oh;
            r_cs_n  <= ~w_win_oh;
            r_cnt   <= '0;
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (r_cnt == SETUP_LAST) begin
            r_cnt   <= '0;
            r_stall <= '0;
            r_state <= ST_WAIT;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_WAIT: begin
          if (w_tx_valid && !eng_busy) begin
            r_eng_tx    <= w_tx_byte;
            r_eng_start <= 1'b1;
            r_last      <= w_tx_last;
            r_stall     <= '0;
            r_state     <= ST_BUSY;
          end else if (r_stall == STALL_LAST) begin
            r_err   <= w_owner_oh;
            r_cnt   <= '0;
            r_state <= ST_HOLD;
          end else begin
            r_stall <= r_stall + 8'd1;
          end
        end
        ST_BUSY: begin
          if (eng_done) begin
            r_rx_data  <= eng_rx;
            r_rx_valid <= w_owner_oh;
            if (r_last) begin
              r_cnt   <= '0;
              r_state <= ST_HOLD;
            end else begin
              r_stall <= '0;
              r_state <= ST_WAIT;
            end
          end
        end
        ST_HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            r_gnt   <= '0;
            r_cs_n  <= '1;
            r_cnt   <= '0;
            r_state <= ST_GAP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gnt         = r_gnt;
  assign cs_n        = r_cs_n;
  assign tx_ready    = w_tx_ready;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign err_timeout = r_err;
  assign eng_start   = r_eng_start;
  assign eng_tx      = r_eng_tx;

endmodule

// File: tb/tb_spi_frame_arbiter.sv
// Testbench for spi_frame_arbiter: random frames from two requesters, an
// engine model with random latency, and a scoreboard monitor.
`timescale 1ns/1ps
module tb_spi_frame_arbiter;

  localparam int unsigned CS_SETUP = 2;
  localparam int unsigned CS_HOLD  = 2;
  localparam int unsigned CS_GAP   = 4;
  localparam int unsigned TIMEOUT  = 255;
  localparam int unsigned NFRAMES  = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req, tx_valid, tx_last;
  logic [15:0] tx_data;
  logic [1:0]  gnt, tx_ready, rx_valid, err_timeout, cs_n;
  logic [7:0]  rx_data, eng_tx, eng_rx;
  logic        eng_start, eng_busy, eng_done;

  // directed-phase drivers
  logic        dir_mode = 1'b1;
  logic [1:0]  d_req = '0, d_valid = '0, d_last = '0;
  logic [15:0] d_data = '0;
  logic        d_busy = 1'b0, d_done = 1'b0;
  logic [7:0]  d_rx = '0;
  // engine model
  logic        m_busy = 1'b0, m_done = 1'b0;
  logic [7:0]  m_rx = '0;

  logic        go = 1'b0, mon_on = 1'b0, eng_on = 1'b0;
  int unsigned drv_done = 0;
  int unsigned n_checks = 0, n_pass = 0;

  logic [8:0]  pend0[$], pend1[$];   // {last, byte} of the frame a requester is asking for
  logic [10:0] exp_tx[$];            // {owner onehot, last, byte}
  logic [7:0]  exp_rxb[$];
  logic [1:0]  exp_err[$];

  always #5 clk = ~clk;

  spi_frame_arbiter #(
    .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .err_timeout(err_timeout),
    .cs_n(cs_n), .eng_start(eng_start), .eng_tx(eng_tx),
    .eng_busy(eng_busy), .eng_done(eng_done), .eng_rx(eng_rx)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Requester drivers
  for (genvar g = 0; g < 2; g++) begin : g_drv
    logic       req_l = 1'b0, v_l = 1'b0, last_l = 1'b0;
    logic [7:0] d_l = '0;
    initial begin
      int unsigned len, k, cnt;
      bit stall, drop;
      logic [7:0] fb [4];
      while (!go) @(negedge clk);
      #1;
      for (int unsigned f = 0; f < NFRAMES; f++) begin
        k = $urandom_range(0, 6);
        repeat (k) begin
          @(negedge clk); #1;
          v_l = 1'($urandom); d_l = 8'($urandom); last_l = 1'($urandom);
        end
        stall = (f == 3 + g * 4);
        drop  = ($urandom_range(0, 2) == 0);
        len   = $urandom_range(1, 4);
        if (!stall) begin
          for (int unsigned j = 0; j < len; j++) begin
            fb[j] = 8'($urandom);
            if (g == 0) pend0.push_back({j == len - 1, fb[j]});
            else        pend1.push_back({j == len - 1, fb[j]});
          end
        end
        req_l = 1'b1;
        k = 0;
        // junk on tx_valid while not granted must be ignored
        while (!gnt[g] && k < 3000) begin
          @(negedge clk); #1;
          v_l = 1'($urandom); d_l = 8'($urandom); last_l = 1'($urandom);
          k++;
        end
        if (k >= 3000) check("grant_wait", 32'(k), 0);
        v_l = 1'b0; last_l = 1'b0;
        if (drop) req_l = 1'b0;
        if (stall) begin
          exp_err.push_back(g == 0 ? 2'b01 : 2'b10);
          cnt = 0; k = 0;
          while (!err_timeout[g] && k < 600) begin
            if (tx_ready[g]) cnt++;
            @(negedge clk); #1;
            k++;
          end
          check("stall_cycles", cnt, TIMEOUT);
        end else begin
          for (int unsigned j = 0; j < len; j++) begin
            repeat ($urandom_range(0, 2)) begin @(negedge clk); #1; end
            v_l = 1'b1; d_l = fb[j]; last_l = (j == len - 1);
            k = 0;
            while (!tx_ready[g] && k < 200) begin @(negedge clk); #1; k++; end
            if (k >= 200) check("tx_ready_wait", 32'(k), 0);
            @(negedge clk); #1;
            v_l = 1'b0; last_l = 1'b0;
          end
        end
        req_l = 1'b0;
        k = 0;
        while (gnt[g] && k < 400) begin @(negedge clk); #1; k++; end
      end
      drv_done++;
    end
  end

  assign req      = dir_mode ? d_req   : {g_drv[1].req_l, g_drv[0].req_l};
  assign tx_valid = dir_mode ? d_valid : {g_drv[1].v_l, g_drv[0].v_l};
  assign tx_last  = dir_mode ? d_last  : {g_drv[1].last_l, g_drv[0].last_l};
  assign tx_data  = dir_mode ? d_data  : {g_drv[1].d_l, g_drv[0].d_l};
  assign eng_busy = dir_mode ? d_busy  : m_busy;
  assign eng_done = dir_mode ? d_done  : m_done;
  assign eng_rx   = dir_mode ? d_rx    : m_rx;

  // Engine model: random shift latency, sometimes stays busy a little after done
  initial begin
    int unsigned lat = 0, xtra = 0;
    forever begin
      @(negedge clk);
      m_done = 1'b0;
      if (!eng_on) begin
        m_busy = 1'b0; lat = 0; xtra = 0;
      end else if (eng_start) begin
        m_busy = 1'b1; lat = $urandom_range(1, 4); xtra = $urandom_range(0, 2);
      end else if (lat > 0) begin
        lat--;
        if (lat == 0) begin
          m_done = 1'b1; m_rx = 8'($urandom);
          exp_rxb.push_back(m_rx);
          if (xtra == 0) m_busy = 1'b0;
        end
      end else if (xtra > 0) begin
        xtra--;
        if (xtra == 0) m_busy = 1'b0;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    logic [1:0]  prev_req = '0, prev_gnt = '0, exp_g, rx_owner = '0;
    logic        prev_busy = 1'b0, ptr = 1'b0, w, end_pend = 1'b0;
    logic        setup_act = 1'b0, hold_act = 1'b0, first = 1'b1;
    int unsigned setup_cnt = 0, hold_cnt = 0, gap_cnt = 0;
    logic [10:0] e;
    logic [8:0]  x;
    logic [7:0]  b;
    forever begin
      @(negedge clk); #2;
      if (mon_on) begin
        check("invariant", {cs_n, tx_ready & ~gnt, rx_valid & ~gnt, err_timeout & ~gnt,
                            1'($countones(gnt) <= 1)},
                           {~gnt, 2'b00, 2'b00, 2'b00, 1'b1});
        if (hold_act) begin
          hold_cnt++;
          if (cs_n == 2'b11 || hold_cnt > CS_HOLD + 8) begin
            check("cs_hold", hold_cnt, CS_HOLD); hold_act = 1'b0;
          end
        end
        if (setup_act) begin
          setup_cnt++;
          if ((tx_ready & gnt) != 0 || setup_cnt > CS_SETUP + 8) begin
            check("cs_setup", setup_cnt, CS_SETUP); setup_act = 1'b0;
          end
        end
        if (prev_gnt == 2'b00 && gnt != 2'b00) begin
          w     = prev_req[ptr] ? ptr : ~ptr;
          exp_g = (prev_req == 2'b00) ? 2'b00 : (w ? 2'b10 : 2'b01);
          check("grant", gnt, exp_g);
          ptr = ~w;
          // cs_n stays high for the gap plus the IDLE arbitration cycle
          if (!first) check("cs_gap", 32'(gap_cnt >= CS_GAP + 1), 1);
          first = 1'b0;
          if (w) while (pend1.size() > 0) begin x = pend1.pop_front(); exp_tx.push_back({exp_g, x}); end
          else   while (pend0.size() > 0) begin x = pend0.pop_front(); exp_tx.push_back({exp_g, x}); end
          setup_act = 1'b1; setup_cnt = 0;
        end
        if (cs_n == 2'b11) gap_cnt++; else gap_cnt = 0;
        if (eng_start) begin
          check("eng_start_pending", 32'(exp_tx.size() > 0), 1);
          if (exp_tx.size() > 0) begin
            e = exp_tx.pop_front();
            check("eng_tx", {gnt, prev_busy, eng_tx}, {e[10:9], 1'b0, e[7:0]});
            rx_owner = e[10:9];
            if (e[8]) end_pend = 1'b1;
          end
        end
        if (rx_valid != 2'b00) begin
          check("rx_pending", 32'(exp_rxb.size() > 0), 1);
          if (exp_rxb.size() > 0) begin
            b = exp_rxb.pop_front();
            check("rx_data", {rx_valid, rx_data}, {rx_owner, b});
          end
          if (end_pend) begin end_pend = 1'b0; hold_act = 1'b1; hold_cnt = 0; end
        end
        if (err_timeout != 2'b00) begin
          check("err_pending", 32'(exp_err.size() > 0), 1);
          if (exp_err.size() > 0) check("err_timeout", err_timeout, exp_err.pop_front());
          hold_act = 1'b1; hold_cnt = 0;
        end
      end
      prev_req  = req;
      prev_gnt  = gnt;
      prev_busy = eng_busy;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k;
    logic [4:0] seen;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", {cs_n, gnt, eng_start, tx_ready, rx_valid, err_timeout, eng_tx, rx_data},
                           {2'b11, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00});
    @(negedge clk);
    rst = 1'b0; dir_mode = 1'b0; mon_on = 1'b1; eng_on = 1'b1; go = 1'b1;

    k = 0;
    while (drv_done < 2 && k < 40000) begin @(negedge clk); k++; end
    check("drivers_done", drv_done, 2);
    repeat (20) @(negedge clk);
    check("tx_queue_empty", exp_tx.size(), 0);
    check("rx_queue_empty", exp_rxb.size(), 0);
    check("err_queue_empty", exp_err.size(), 0);

    // Reset in the middle of a byte transfer
    mon_on = 1'b0; eng_on = 1'b0; dir_mode = 1'b1;
    d_req = 2'b01; d_valid = '0; d_last = '0; d_busy = 1'b0; d_done = 1'b0;
    k = 0;
    while (gnt != 2'b01 && k < 50) begin @(negedge clk); #1; k++; end
    check("t4_grant", gnt, 2'b01);
    d_valid = 2'b01; d_data = 16'h0011; d_last = 2'b01;
    k = 0;
    while (!eng_start && k < 50) begin @(negedge clk); #1; k++; end
    check("t4_start", {eng_start, eng_tx}, {1'b1, 8'h11});
    d_valid = '0; d_last = '0; d_busy = 1'b1;
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    check("t4_reset", {cs_n, gnt, eng_start, tx_ready, rx_valid, err_timeout, eng_tx, rx_data},
                      {2'b11, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00});
    rst = 1'b0; d_req = '0; d_busy = 1'b0;
    @(negedge clk); #1;
    d_done = 1'b1; d_rx = 8'hEE;
    @(negedge clk); #1;
    d_done = 1'b0;
    seen = '0;
    repeat (4) begin
      @(negedge clk); #1;
      seen |= {|rx_valid, rx_data != 8'h00, eng_start, cs_n != 2'b11, gnt != 2'b00};
    end
    check("t4_done_ignored", seen, 0);
    // pointer returns to requester 0 after reset
    d_req = 2'b11;
    k = 0;
    while (gnt == 2'b00 && k < 50) begin @(negedge clk); #1; k++; end
    check("rr_after_reset", gnt, 2'b01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
